// File: rtl/jtag_tap_master.sv
// jtag_tap_master
// Initiator for a boundary-scan TAP. It takes one IR or DR shift command at a
// time and walks the TAP from Run-Test/Idle back to Run-Test/Idle. It then
// returns the TDO bits captured during the shift.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_is_ir, cmd_len, cmd_data qualify it
//   rsp_valid            one-clk response pulse; rsp_err flags an illegal length
//   rsp_data             captured TDO, bit i = i-th shift bit, held until next response
//   tck, tms, tdi        outputs to the TAP
//   tdo                  input from the TAP
//   trstn                TAP reset, active-low
//
// state    | meaning
// ST_RST   | 5 TCKs with tms=1, then 1 TCK with tms=0 (TLR -> Run-Test/Idle)
// ST_IDLE  | ready for a command, tck parked low
// ST_LOAD  | command latched, length checked
// ST_HDR   | Select-DR[/IR], Capture, Shift entry
// ST_SHIFT | cmd_len data bits, tms=1 on the last bit (Exit1)
// ST_TRL   | Update, then back to Run-Test/Idle
// ST_DONE  | response pulse, already able to accept the next command
// ST_ERR   | error response pulse for an illegal length, no TCK activity

module jtag_tap_master #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_ir,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               trstn
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    localparam logic [6:0]    LEN_MAX  = 7'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_RST, ST_IDLE, ST_LOAD, ST_HDR, ST_SHIFT, ST_TRL, ST_DONE, ST_ERR
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [5:0]          r_cnt;
    logic [5:0]          w_cnt_n;
    logic                r_run;
    logic [DW-1:0]       r_div;
    logic                r_tck;
    logic                r_tms;
    logic                r_tdi;
    logic                r_trstn;
    logic                r_is_ir;
    logic [5:0]          r_len;
    logic [MAX_LEN-1:0]  r_data;
    logic [MAX_LEN-1:0]  r_cap;
    logic [MAX_LEN-1:0]  r_rsp_data;

    logic                w_tick;
    logic                w_rise;
    logic                w_fall;
    logic                w_last;
    logic                w_load;
    logic                w_accept;
    logic                w_len_ok;
    logic [5:0]          w_len_m1;
    logic                w_tms_n;
    logic                w_tdi_n;

    // TCK engine: r_div counts clks left in the current phase. A phase ends
    // when it reaches zero.
    assign w_tick   = r_run && (r_div == '0);
    assign w_rise   = w_tick && !r_tck;
    assign w_fall   = w_tick && r_tck;
    assign w_accept = cmd_valid && cmd_ready;
    assign w_len_m1 = r_len - 6'd1;
    assign w_len_ok = (r_len != 6'd0) && ({1'b0, r_len} <= LEN_MAX);

    // A new low phase starts either at the end of a high phase or when a
    // checked command leaves ST_LOAD. In both cases tms/tdi are loaded for the
    // TCK that follows.
    assign w_load = (w_fall || (r_state == ST_LOAD)) &&
                    (w_state_n inside {ST_RST, ST_HDR, ST_SHIFT, ST_TRL});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RST;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        case (r_state)
            ST_RST:   w_last = (r_cnt == 6'd5);
            ST_HDR:   w_last = (r_cnt == (r_is_ir ? 6'd3 : 6'd2));
            ST_SHIFT: w_last = (r_cnt == w_len_m1);
            ST_TRL:   w_last = (r_cnt == 6'd1);
            default:  w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_n = w_accept ? ST_LOAD : ST_IDLE;
                w_cnt_n   = 6'd0;
            end
            ST_LOAD: begin
                w_state_n = w_len_ok ? ST_HDR : ST_ERR;
                w_cnt_n   = 6'd0;
            end
            ST_ERR: w_state_n = ST_IDLE;
            ST_RST, ST_HDR, ST_SHIFT, ST_TRL: begin
                if (w_fall) begin
                    if (w_last) begin
                        w_cnt_n = 6'd0;
                        case (r_state)
                            ST_RST:   w_state_n = ST_IDLE;
                            ST_HDR:   w_state_n = ST_SHIFT;
                            ST_SHIFT: w_state_n = ST_TRL;
                            default:  w_state_n = ST_DONE;
                        endcase
                    end else begin
                        w_cnt_n = r_cnt + 6'd1;
                    end
                end
            end
            default: w_state_n = ST_RST;
        endcase
    end

    // Output decode. tms/tdi are computed for the TCK that is about to start.
    always_comb begin
        w_tms_n = r_tms;
        w_tdi_n = r_tdi;
        case (w_state_n)
            ST_RST: begin
                w_tms_n = (w_cnt_n != 6'd5);
                w_tdi_n = 1'b0;
            end
            ST_HDR: begin
                w_tms_n = r_is_ir ? (w_cnt_n <= 6'd1) : (w_cnt_n == 6'd0);
                w_tdi_n = 1'b0;
            end
            ST_SHIFT: begin
                w_tms_n = (w_cnt_n == w_len_m1);
                w_tdi_n = r_data[w_cnt_n[IW-1:0]];
            end
            ST_TRL: begin
                w_tms_n = (w_cnt_n == 6'd0);
                w_tdi_n = 1'b0;
            end
            default: ;
        endcase
        cmd_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
        rsp_valid = (r_state == ST_DONE) || (r_state == ST_ERR);
        rsp_err   = (r_state == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // The reset sequence's first low phase begins on the last reset clk.
            r_run      <= 1'b1;
            r_div      <= DIV_LOAD;
            r_tck      <= 1'b0;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b0;
            r_trstn    <= 1'b0;
            r_is_ir    <= 1'b0;
            r_len      <= 6'd0;
            r_data     <= '0;
            r_cap      <= '0;
            r_rsp_data <= '0;
        end else begin
            r_trstn <= 1'b1;
            if (r_run) begin
                if (w_tick) begin
                    r_div <= DIV_LOAD;
                    r_tck <= ~r_tck;
                end else begin
                    r_div <= r_div - 1'b1;
                end
            end
            if (w_load) begin
                r_run <= 1'b1;
                r_div <= DIV_LOAD;
                r_tms <= w_tms_n;
                r_tdi <= w_tdi_n;
            end else if (w_fall) begin
                r_run <= 1'b0;
            end
            if (w_accept) begin
                r_is_ir <= cmd_is_ir;
                r_len   <= cmd_len;
                r_data  <= cmd_data;
                r_cap   <= '0;
            end
            if (w_rise && (r_state == ST_SHIFT))
                r_cap[r_cnt[IW-1:0]] <= tdo;
            if ((r_state == ST_LOAD) && !w_len_ok)
                r_rsp_data <= '0;
            if ((r_state == ST_TRL) && (w_state_n == ST_DONE))
                r_rsp_data <= r_cap;
        end
    end

    assign tck      = r_tck;
    assign tms      = r_tms;
    assign tdi      = r_tdi;
    assign trstn    = r_trstn;
    assign rsp_data = r_rsp_data;

endmodule
